// File: rtl/fml_sram_responder.sv
// rtl/fml_sram_responder.sv - FML read-burst responder backed by an async 16-bit SRAM
// Fetches four words into a local buffer, then replays them as an acked four-beat burst.
module fml_sram_responder #(
    parameter int fml_depth   = 25,
    parameter int sram_aw     = 20,
    parameter int wait_states = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [fml_depth-1:0] fml_adr,
    input  logic                 fml_stb,
    output logic                 fml_ack,
    output logic [15:0]          fml_di,
    output logic [sram_aw-1:0]   sram_adr,
    input  logic [15:0]          sram_dq,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, FETCH, ACK, BEAT} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [sram_aw-1:2]     r_base;
    logic [1:0]             r_beat;
    logic [2:0]             r_wait;
    logic [15:0]            r_buf [4];
    logic                   r_fml_ack;
    logic [15:0]            r_fml_di;

    // Word address widened so it can be truncated or zero-extended to sram_aw alike.
    logic [fml_depth-2+sram_aw:0] w_word_ext;
    logic                         w_last_wait;
    logic                         w_unused_ok;

    assign w_word_ext  = {{sram_aw{1'b0}}, fml_adr[fml_depth-1:1]};
    assign w_last_wait = (r_wait == 3'(wait_states));
    assign w_unused_ok = &{1'b0, fml_adr[0], w_word_ext};

    always_comb begin
        w_next    = r_state;
        sram_adr  = '0;
        sram_ce_n = 1'b1;
        sram_oe_n = 1'b1;
        case (r_state)
            IDLE: begin
                if (fml_stb) w_next = FETCH;
            end
            FETCH: begin
                sram_adr  = {r_base, r_beat};
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                if (w_last_wait && r_beat == 2'd3) w_next = ACK;
            end
            ACK: begin
                w_next = BEAT;
            end
            BEAT: begin
                if (r_beat == 2'd3) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_base    <= '0;
            r_beat    <= '0;
            r_wait    <= '0;
            r_fml_ack <= 1'b0;
            r_fml_di  <= 16'h0;
            for (int i = 0; i < 4; i++) r_buf[i] <= 16'h0;
        end else begin
            r_state   <= w_next;
            r_fml_ack <= (r_state == ACK);
            r_fml_di  <= 16'h0;
            case (r_state)
                IDLE: begin
                    if (fml_stb) begin
                        r_base <= w_word_ext[sram_aw-1:2];
                        r_beat <= 2'd0;
                        r_wait <= 3'd0;
                    end
                end
                FETCH: begin
                    // Data is sampled on the last cycle of each access, address held stable throughout.
                    if (w_last_wait) begin
                        r_buf[r_beat] <= sram_dq;
                        r_beat        <= r_beat + 2'd1;
                        r_wait        <= 3'd0;
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end
                ACK: begin
                    r_fml_di <= r_buf[0];
                    r_beat   <= 2'd1;
                end
                BEAT: begin
                    r_fml_di <= r_buf[r_beat];
                    r_beat   <= r_beat + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign fml_ack   = r_fml_ack;
    assign fml_di    = r_fml_di;
    assign sram_we_n = 1'b1;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fml_sram_responder.sv
// tb/tb_fml_sram_responder.sv - bench for fml_sram_responder with one and zero wait states
// SRAM models return word address XOR 16'hA5A5; expected beats travel through a scoreboard queue.
module tb_fml_sram_responder;

    logic        clk;
    logic        rst;
    logic [24:0] adr1, adr0;
    logic        stb1, stb0;
    logic        ack1, ack0;
    logic [15:0] di1, di0;
    logic [19:0] sadr1, sadr0;
    logic [15:0] dq1, dq0;
    logic        ce1, ce0, oe1, oe0, we1, we0;
    logic        busy1, busy0;

    int          n_checks;
    int          n_errors;
    logic [15:0] exp_q [$];

    fml_sram_responder #(.fml_depth(25), .sram_aw(20), .wait_states(1)) dut1 (
        .clk(clk), .rst(rst), .fml_adr(adr1), .fml_stb(stb1), .fml_ack(ack1), .fml_di(di1),
        .sram_adr(sadr1), .sram_dq(dq1), .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1),
        .busy(busy1)
    );

    fml_sram_responder #(.fml_depth(25), .sram_aw(20), .wait_states(0)) dut0 (
        .clk(clk), .rst(rst), .fml_adr(adr0), .fml_stb(stb0), .fml_ack(ack0), .fml_di(di0),
        .sram_adr(sadr0), .sram_dq(dq0), .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0),
        .busy(busy0)
    );

    assign dq1 = sadr1[15:0] ^ 16'hA5A5;
    assign dq0 = sadr0[15:0] ^ 16'hA5A5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one request and follows it cycle by cycle; returns in the IDLE cycle after beat 3.
    task automatic burst(input bit ws0, input logic [24:0] adr, input bit early_drop, output int acks);
        int          wsp1;
        int          lat;
        int          beats;
        logic [19:0] base;
        logic [19:0] a;
        logic [15:0] exp_w;
        logic        o_ack, o_ce, o_oe, o_busy;
        logic [15:0] o_di;
        logic [19:0] o_adr;
        wsp1  = ws0 ? 1 : 2;
        lat   = 1 + 4 * wsp1;
        base  = {adr[20:3], 2'b00};
        for (int i = 0; i < 4; i++) begin
            a = base | 20'(i);
            exp_q.push_back(a[15:0] ^ 16'hA5A5);
        end
        if (ws0) begin adr0 = adr; stb0 = 1'b1; end
        else     begin adr1 = adr; stb1 = 1'b1; end
        tick();
        if (early_drop) begin stb0 = 1'b0; stb1 = 1'b0; end
        acks  = 0;
        beats = 0;
        for (int n = 0; n <= lat + 3; n++) begin
            o_ack  = ws0 ? ack0  : ack1;
            o_di   = ws0 ? di0   : di1;
            o_adr  = ws0 ? sadr0 : sadr1;
            o_ce   = ws0 ? ce0   : ce1;
            o_oe   = ws0 ? oe0   : oe1;
            o_busy = ws0 ? busy0 : busy1;
            check("sram_adr", o_adr, (n < 4 * wsp1) ? (base | 20'(n / wsp1)) : 20'h0);
            check("sram_ce_n", o_ce, (n < 4 * wsp1) ? 0 : 1);
            check("sram_oe_n", o_oe, (n < 4 * wsp1) ? 0 : 1);
            check("fml_ack", o_ack, (n == lat) ? 1 : 0);
            check("busy", o_busy, (n < lat + 3) ? 1 : 0);
            if (o_ack || (beats > 0 && beats < 4)) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("fml_di", o_di, exp_w);
                end
                beats++;
            end else begin
                check("fml_di_idle", o_di, 16'h0);
            end
            if (o_ack) begin
                acks++;
                stb0 = 1'b0;
                stb1 = 1'b0;
            end
            if (n < lat + 3) tick();
        end
        check("beat_count", beats, 4);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        int acks_a;
        int acks_b;
        n_checks = 0;
        n_errors = 0;
        rst  = 1'b1;
        stb1 = 1'b0; stb0 = 1'b0;
        adr1 = '0;   adr0 = '0;
        repeat (3) tick();

        check("rst_ack", {ack1, ack0}, 2'b00);
        check("rst_di", {di1, di0}, 32'h0);
        check("rst_sram_adr", sadr1, 20'h0);
        check("rst_ce_oe_we", {ce1, oe1, we1, ce0, oe0, we0}, 6'b111111);
        check("rst_busy", {busy1, busy0}, 2'b00);
        rst = 1'b0;
        tick();

        // Reset in the middle of a fetch: the burst is abandoned with no ack.
        adr1 = 25'h000040;
        stb1 = 1'b1;
        repeat (3) tick();
        check("mid_fetch_busy", busy1, 1);
        stb1 = 1'b0;
        rst  = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("mid_rst_ce_oe", {ce1, oe1}, 2'b11);
        check("mid_rst_ack", ack1, 0);
        check("mid_rst_busy", busy1, 0);
        check("mid_rst_di", di1, 16'h0);
        check("mid_rst_sram_adr", sadr1, 20'h0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("no_partial_ack", ack1, 0);
        end

        burst(1'b0, 25'h000108, 1'b0, acks_a);
        check("single_acks", acks_a, 1);
        repeat (2) tick();

        burst(1'b0, 25'h00010E, 1'b0, acks_a);
        check("align_acks", acks_a, 1);
        repeat (2) tick();

        // Second request presented in the IDLE cycle right after beat 3.
        burst(1'b0, 25'h000000, 1'b0, acks_a);
        burst(1'b0, 25'h000008, 1'b0, acks_b);
        check("b2b_acks", acks_a + acks_b, 2);
        repeat (2) tick();

        burst(1'b0, 25'h0001A0, 1'b1, acks_a);
        check("early_drop_acks", acks_a, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("early_drop_idle", {busy1, ack1}, 2'b00);
        end

        burst(1'b1, 25'h1FFFFF8, 1'b0, acks_a);
        check("ws0_acks", acks_a, 1);
        burst(1'b1, 25'h0000010, 1'b0, acks_a);
        check("ws0_b2b_acks", acks_a, 1);
        repeat (3) tick();
        check("final_idle", {busy1, busy0, ack1, ack0}, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
